// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable clock-enable / divided-clock generator.
// A counter runs 0..div_act-1 and raises a one-cycle tick on the terminal edge.
// d_clk either toggles once per period (TOGGLE) or copies the tick (PULSE).
// A new divisor is staged in a shadow register and only becomes active on a
// period boundary, so the divided clock never sees a shortened period.
// While the generator is idle (disabled or divisor 0), a load applies at once.

module clk_div_gen #(
   parameter int CNT_W       = 27,
   parameter int DEFAULT_DIV = 500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync_clr,
   input  logic             mode,
   input  logic             load,
   input  logic [CNT_W-1:0] div_in,
   output logic             d_clk,
   output logic             tick,
   output logic [CNT_W-1:0] cnt_o,
   output logic             pending,
   output logic             div_err
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   localparam logic MODE_TOGGLE = 1'b0;
   localparam logic MODE_PULSE  = 1'b1;

   // Per-edge action, decoded once in priority order.
   localparam logic [2:0] OP_COUNT     = 3'd0;
   localparam logic [2:0] OP_TERM      = 3'd1;
   localparam logic [2:0] OP_HOLD      = 3'd2;
   localparam logic [2:0] OP_IDLE_LOAD = 3'd3;
   localparam logic [2:0] OP_CLEAR     = 3'd4;

   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [CNT_W-1:0] div_act_q, div_act_d;
   logic [CNT_W-1:0] div_shd_q, div_shd_d;
   logic             pending_q, pending_d;
   logic             d_clk_q,   d_clk_d;
   logic             tick_q,    tick_d;
   logic             div_err_q, div_err_d;

   logic [CNT_W-1:0] div_m1;
   logic             div_zero;
   logic             idle;
   logic             at_term;
   logic             overrun;
   logic [2:0]       op;

   // Next count for a running counter: advance, or wrap silently when a
   // shrunken divisor left the count beyond the new terminal value.
   function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                   input logic             past_end);
      if (past_end) begin
         next_count = '0;
      end else begin
         next_count = cur + CNT_ONE;
      end
   endfunction

   // Terminal and idle qualifiers; div_m1 is taken in CNT_W bits and only used
   // when the divisor is nonzero, so the wrap of 0-1 never matters.
   always_comb begin
      div_zero = (div_act_q == '0);
      div_m1   = div_act_q - CNT_ONE;
      idle     = ~en | div_zero;
      at_term  = (cnt_q == div_m1);
      overrun  = (cnt_q > div_m1);
   end

   // Action decode: sync_clr > load-while-idle > idle hold > terminal > count.
   always_comb begin
      op = OP_COUNT;
      if (sync_clr) begin
         op = OP_CLEAR;
      end else if (idle && load) begin
         op = OP_IDLE_LOAD;
      end else if (idle) begin
         op = OP_HOLD;
      end else if (at_term) begin
         op = OP_TERM;
      end
   end

   // Counter next state.
   always_comb begin
      cnt_d = cnt_q;
      case (op)
         OP_CLEAR:     cnt_d = '0;
         OP_IDLE_LOAD: cnt_d = '0;
         OP_HOLD:      cnt_d = div_zero ? '0 : cnt_q;
         OP_TERM:      cnt_d = '0;
         OP_COUNT:     cnt_d = next_count(cnt_q, overrun);
         default:      cnt_d = cnt_q;
      endcase
   end

   // Tick and divided-clock next state.
   always_comb begin
      tick_d  = (op == OP_TERM);
      d_clk_d = d_clk_q;
      case (op)
         OP_CLEAR: d_clk_d = 1'b0;
         OP_TERM:  d_clk_d = (mode == MODE_PULSE) ? 1'b1 : ~d_clk_q;
         default: begin
            // PULSE forces d_clk low off the terminal edge; TOGGLE holds phase.
            if (mode == MODE_PULSE) begin
               d_clk_d = 1'b0;
            end else if (mode == MODE_TOGGLE) begin
               d_clk_d = d_clk_q;
            end
         end
      endcase
   end

   // Divisor shadowing: stage loads mid-period, commit them on a boundary.
   always_comb begin
      div_act_d = div_act_q;
      div_shd_d = div_shd_q;
      pending_d = pending_q;
      case (op)
         OP_CLEAR: begin
            // Clearing is a boundary too; a coincident load is discarded.
            if (pending_q) begin
               div_act_d = div_shd_q;
               pending_d = 1'b0;
            end
         end
         OP_IDLE_LOAD: begin
            div_act_d = div_in;
            div_shd_d = div_in;
            pending_d = 1'b0;
         end
         OP_TERM: begin
            if (load) begin
               div_act_d = div_in;
               div_shd_d = div_in;
               pending_d = 1'b0;
            end else if (pending_q) begin
               div_act_d = div_shd_q;
               pending_d = 1'b0;
            end
         end
         OP_COUNT: begin
            if (load) begin
               div_shd_d = div_in;
               pending_d = 1'b1;
            end
         end
         default: begin
            div_act_d = div_act_q;
         end
      endcase
      div_err_d = (div_act_d == '0);
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         div_act_q <= DIV_RST;
         div_shd_q <= DIV_RST;
         pending_q <= 1'b0;
         d_clk_q   <= 1'b0;
         tick_q    <= 1'b0;
         div_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_act_q <= div_act_d;
         div_shd_q <= div_shd_d;
         pending_q <= pending_d;
         d_clk_q   <= d_clk_d;
         tick_q    <= tick_d;
         div_err_q <= div_err_d;
      end
   end

   assign d_clk   = d_clk_q;
   assign tick    = tick_q;
   assign cnt_o   = cnt_q;
   assign pending = pending_q;
   assign div_err = div_err_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed scenarios followed by random stimulus, checked by a
// scoreboard fed from a behavioural model of the divider.

module tb_clk_div_gen;

   localparam int CW = 8;
   localparam int DD = 4;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic          sync_clr;
   logic          mode;
   logic          load;
   logic [CW-1:0] div_in;
   logic          d_clk;
   logic          tick;
   logic [CW-1:0] cnt_o;
   logic          pending;
   logic          div_err;

   clk_div_gen #(.CNT_W(CW), .DEFAULT_DIV(DD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sync_clr (sync_clr),
      .mode     (mode),
      .load     (load),
      .div_in   (div_in),
      .d_clk    (d_clk),
      .tick     (tick),
      .cnt_o    (cnt_o),
      .pending  (pending),
      .div_err  (div_err)
   );

   typedef struct {
      int cnt;
      int dclk;
      int tick;
      int pend;
      int err;
   } exp_t;

   exp_t exp_q[$];

   int n_vec;
   int n_bad;
   int n_push;
   int n_pop;

   // Reference model state: position within the period, active and staged divisor.
   int m_cnt;
   int m_act;
   int m_shd;
   int m_pend;
   int m_dclk;
   int m_tick;
   int cur_mode;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_act  = DD;
      m_shd  = DD;
      m_pend = 0;
      m_dclk = 0;
      m_tick = 0;
   endtask

   // One clock edge of the divider described by its rules, not its circuit.
   task automatic model_edge(input int e, input int c, input int m, input int l, input int d);
      if (c != 0) begin
         m_cnt  = 0;
         m_dclk = 0;
         m_tick = 0;
         if (m_pend != 0) begin
            m_act  = m_shd;
            m_pend = 0;
         end
      end else if (e == 0 || m_act == 0) begin
         m_tick = 0;
         if (m != 0) m_dclk = 0;
         if (l != 0) begin
            m_act  = d;
            m_shd  = d;
            m_pend = 0;
            m_cnt  = 0;
         end else if (m_act == 0) begin
            m_cnt = 0;
         end
      end else if (m_cnt == m_act - 1) begin
         m_tick = 1;
         m_cnt  = 0;
         m_dclk = (m != 0) ? 1 : 1 - m_dclk;
         if (l != 0) begin
            m_act  = d;
            m_shd  = d;
            m_pend = 0;
         end else if (m_pend != 0) begin
            m_act  = m_shd;
            m_pend = 0;
         end
      end else begin
         m_tick = 0;
         m_cnt  = (m_cnt >= m_act) ? 0 : (m_cnt + 1) % m_act;
         if (m != 0) m_dclk = 0;
         if (l != 0) begin
            m_shd  = d;
            m_pend = 1;
         end
      end
   endtask

   // Drive inputs for the coming edge and queue the outputs expected after it.
   task automatic apply(input int e, input int c, input int m, input int l, input int d);
      exp_t x;
      en       = (e != 0);
      sync_clr = (c != 0);
      mode     = (m != 0);
      load     = (l != 0);
      div_in   = CW'(d);
      cur_mode = m;
      model_edge(e, c, m, l, d);
      x.cnt  = m_cnt;
      x.dclk = m_dclk;
      x.tick = m_tick;
      x.pend = m_pend;
      x.err  = (m_act == 0) ? 1 : 0;
      exp_q.push_back(x);
      n_push++;
   endtask

   task automatic step(input int e, input int c, input int m, input int l, input int d);
      @(posedge clk);
      #2;
      apply(e, c, m, l, d);
   endtask

   task automatic run(input int n, input int m);
      for (int i = 0; i < n; i++) step(1, 0, m, 0, 0);
   endtask

   // Count freely until the model reaches the wanted count, bounded.
   task automatic run_to_cnt(input int target, input int m);
      int guard;
      guard = 0;
      while (m_cnt != target && guard < 64) begin
         step(1, 0, m, 0, 0);
         guard++;
      end
      chk("reach_cnt", m_cnt, target);
   endtask

   // Mid-cycle asynchronous reset: outputs must clear before any clock edge.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_cnt",     int'(cnt_o),   0);
      chk("rst_dclk",    int'(d_clk),   0);
      chk("rst_tick",    int'(tick),    0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_div_err", int'(div_err), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_reset();
      apply(1, 0, 0, 0, 0);
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_pop++;
            chk("cnt_o",   int'(cnt_o),   x.cnt);
            chk("d_clk",   int'(d_clk),   x.dclk);
            chk("tick",    int'(tick),    x.tick);
            chk("pending", int'(pending), x.pend);
            chk("div_err", int'(div_err), x.err);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, c, m, l, d;
      n_vec = 0; n_bad = 0; n_push = 0; n_pop = 0;
      rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; mode = 1'b0; load = 1'b0; div_in = '0;
      cur_mode = 0;
      model_reset();
      repeat (2) @(posedge clk);

      // Free-running TOGGLE after reset: ticks on edges 4, 8, 12.
      do_reset();
      run(14, 0);

      // PULSE mode, then divisor 1 (tick every cycle), then back to 4.
      run(10, 1);
      step(1, 0, 1, 1, 1);
      run(6, 1);
      step(1, 0, 0, 1, 4);
      run(6, 0);

      // Staged load mid-period, then a load coinciding with the terminal edge.
      run_to_cnt(1, 0);
      step(1, 0, 0, 1, 6);
      run(15, 0);
      run_to_cnt(5, 0);
      step(1, 0, 0, 1, 4);
      run(10, 0);

      // Freeze at cnt=2, then re-enable.
      run_to_cnt(2, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      run(4, 0);

      // Divisor 0 stops the counter; loading 3 restarts at once.
      step(1, 0, 0, 1, 0);
      run(8, 0);
      step(1, 0, 0, 1, 3);
      run(10, 0);

      // Mode switch mid-period, sync_clr with a discarded load, async reset.
      run(2, 1);
      run(3, 0);
      run_to_cnt(2, 0);
      step(1, 1, 0, 1, 7);
      run(5, 0);
      do_reset();
      run(6, 0);

      // Random phase.
      for (int i = 0; i < 3000; i++) begin
         e = (($urandom % 10) != 0) ? 1 : 0;
         c = (($urandom % 40) == 0) ? 1 : 0;
         m = (($urandom % 30) == 0) ? 1 - cur_mode : cur_mode;
         l = (($urandom % 12) == 0) ? 1 : 0;
         d = (($urandom % 20) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
         if (($urandom % 500) == 0) begin
            do_reset();
         end else begin
            step(e, c, m, l, d);
         end
      end

      repeat (3) @(posedge clk);
      #2;
      chk("drain", n_pop, n_push);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
